// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM state encoding, default geometry and address field helpers.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2
  } state_e;

  localparam int DEF_TAG_WIDTH    = 2;
  localparam int DEF_INDEX_WIDTH  = 5;
  localparam int DEF_OFFSET_WIDTH = 3;
  localparam int DEF_ADDR_WIDTH   = DEF_TAG_WIDTH + DEF_INDEX_WIDTH + DEF_OFFSET_WIDTH;
  localparam int DEF_DATA_WIDTH   = 32;

  localparam int NUM_LINES      = 1 << DEF_INDEX_WIDTH;
  localparam int WORDS_PER_LINE = 1 << DEF_OFFSET_WIDTH;

  // Low 'w' bits set.
  function automatic logic [31:0] field_mask(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Word offset within the line: addr[ow-1:0].
  function automatic logic [31:0] addr_offset(input logic [31:0] a, input int ow);
    return a & field_mask(ow);
  endfunction

  // Line index: addr[ow+iw-1:ow].
  function automatic logic [31:0] addr_index(input logic [31:0] a, input int ow, input int iw);
    return (a >> ow) & field_mask(iw);
  endfunction

  // Tag: addr[ow+iw+tw-1:ow+iw].
  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int ow, input int iw,
                                           input int tw);
    return (a >> (ow + iw)) & field_mask(tw);
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid/dirty/tag storage for the direct-mapped cache. One index selects
// the line for both the combinational lookup and the write ports.
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] index_i,
  input  logic [TAG_WIDTH-1:0]   tag_i,
  output logic                   valid_o,
  output logic                   dirty_o,
  output logic [TAG_WIDTH-1:0]   tag_o,
  output logic                   match_o,
  input  logic                   set_dirty_i,  // store hit: mark line dirty
  input  logic                   fill_i        // refill done: valid, new tag, clean
);

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_WIDTH-1:0] tag_q [LINES];

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign match_o = valid_o && (tag_o == tag_i);

  // Line state update: reset invalidates everything, fill installs a clean line.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
    end else if (fill_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
      tag_q[index_i]   <= tag_i;
    end else if (set_dirty_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Misses stall the pipeline (hit low) while an FSM writes back a dirty
// line and refills from a synchronous-read BRAM.
// Optional build macro DCACHE_STATS_EN adds saturating hit/miss counters.
module dcache_wb_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int INDEX_WIDTH        = DEF_INDEX_WIDTH,
  parameter int TAG_WIDTH          = DEF_TAG_WIDTH,
  parameter int BLOCK_OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  we,
  input  logic                  mem_en,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int OW    = BLOCK_OFFSET_WIDTH;
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << OW;
  localparam int KW    = OW + 1;  // counts 0..WORDS for the refill tail cycle

  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);
  localparam logic [KW-1:0] K_DONE = KW'(WORDS);

  // Address fields
  logic [TAG_WIDTH-1:0]   cpu_tag;
  logic [INDEX_WIDTH-1:0] cpu_index;
  logic [OW-1:0]          cpu_offset;

  assign cpu_tag    = TAG_WIDTH'(addr_tag(32'(addr), OW, INDEX_WIDTH, TAG_WIDTH));
  assign cpu_index  = INDEX_WIDTH'(addr_index(32'(addr), OW, INDEX_WIDTH));
  assign cpu_offset = OW'(addr_offset(32'(addr), OW));

  // FSM and word counter
  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [OW-1:0] k_word;
  logic [OW-1:0] k_prev_word;

  assign k_word      = k_q[OW-1:0];
  assign k_prev_word = OW'(k_q - KW'(1));

  // Line state from the tag array
  logic                 line_valid;
  logic                 line_dirty;
  logic [TAG_WIDTH-1:0] line_tag;
  logic                 line_match;

  // Control strobes
  logic store_hit;
  logic fill;
  logic refill_wr;

  // Data array, flattened as {index, word}
  logic [DATA_WIDTH-1:0] data_q [LINES*WORDS];

  dcache_tag_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_tag_array (
    .clk         (clk),
    .rst         (rst),
    .index_i     (cpu_index),
    .tag_i       (cpu_tag),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .match_o     (line_match),
    .set_dirty_i (store_hit),
    .fill_i      (fill)
  );

  // Hit only reported in IDLE, so a completing refill never hits early.
  assign hit  = (state_q == IDLE) && line_match;
  assign dout = data_q[{cpu_index, cpu_offset}];

  // State and word counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state, BRAM port and array strobe decode.
  // NOTE: every output of this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    store_hit = 1'b0;
    fill      = 1'b0;
    refill_wr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_en) begin
          if (hit) begin
            store_hit = we;
          end else begin
            k_d     = '0;
            state_d = (line_valid && line_dirty) ? WB : REFILL;
          end
        end
      end
      WB: begin
        mem_we    = 1'b1;
        mem_addr  = {line_tag, cpu_index, k_word};
        mem_wdata = data_q[{cpu_index, k_word}];
        if (k_q == K_LAST) begin
          state_d = REFILL;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      REFILL: begin
        // Address phase runs k=0..7; read data trails by one cycle (k=1..8).
        if (k_q <= K_LAST) mem_addr = {cpu_tag, cpu_index, k_word};
        if (k_q != '0) refill_wr = 1'b1;
        if (k_q == K_DONE) begin
          fill    = 1'b1;
          state_d = IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data array writes: store hits from the CPU, refill words from the BRAM.
  // NOTE: the data array is reset explicitly because dout must read zero
  // after reset; this keeps it out of plain RAM macros.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES * WORDS; i++) data_q[i] <= '0;
    end else if (store_hit) begin
      data_q[{cpu_index, cpu_offset}] <= din;
    end else if (refill_wr) begin
      data_q[{cpu_index, k_prev_word}] <= mem_rdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        after_refill_q;
  logic        hit_event;
  logic        miss_event;

  // The cycle that completes a refill is the miss itself, not a fresh hit.
  assign miss_event = (state_q == IDLE) && mem_en && !hit;
  assign hit_event  = (state_q == IDLE) && mem_en && hit && !after_refill_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
      after_refill_q <= 1'b0;
    end else begin
      after_refill_q <= fill;
      if (hit_event && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_event && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  // Statistics disabled: no counter state or ports.
`endif

endmodule
